// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low segment
// patterns {dp,g,f,e,d,c,b,a}, scan state encoding and legal parameter ranges.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        OFF,
        DRIVE,
        GUARD
    } seg_state_t;

    localparam int unsigned NUM_DIGITS_MIN  = 2;
    localparam int unsigned NUM_DIGITS_MAX  = 8;
    localparam int unsigned REFRESH_DIV_MIN = 2;
    localparam int unsigned GUARD_CYC_MIN   = 1;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; codes 10-15 or a set blank
// flag give an all-off pattern. Decimal point is never lit.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-aligned digit commit.
// Define SEG_SCAN_LZB_EN to blank leading zeros (digit 0 is always shown).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD_CYC   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic                    load_done,
    output logic                    pending,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned DW      = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX ||
        REFRESH_DIV < REFRESH_DIV_MIN || GUARD_CYC < GUARD_CYC_MIN) begin : g_param_check
        $error("seg_scan_ctrl: parameter out of legal range");
    end

    seg_state_t            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [DW-1:0]         r_shadow;
    logic [DW-1:0]         r_staging;
    logic                  r_pending;
    logic                  r_load_done;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    seg_state_t            w_state_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DW-1:0]         w_shadow_nxt;
    logic                  w_boundary;
    logic                  w_commit;
    logic                  w_drive;
    logic                  w_lz_blank;
    logic [3:0]            w_digit;
    logic [7:0]            w_seg_dec;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            OFF: begin
                if (en) begin
                    w_state_nxt = DRIVE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            DRIVE: begin
                if (r_cnt == DRIVE_LAST) begin
                    w_state_nxt = GUARD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            GUARD: begin
                if (r_cnt == GUARD_LAST) begin
                    w_state_nxt = DRIVE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = OFF;
        endcase
        if (!en) begin
            w_state_nxt = OFF;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end
    end

    // Commit sees the old staging even when a new load lands on the same cycle.
    assign w_boundary   = (r_state == GUARD) && (r_cnt == GUARD_LAST) && (r_idx == IDX_LAST);
    assign w_commit     = r_pending && (w_boundary || (r_state == OFF));
    assign w_shadow_nxt = w_commit ? r_staging : r_shadow;

    // Outputs are decoded from next-cycle values so the registered pins line up with the state.
    assign w_drive = (w_state_nxt == DRIVE);
    assign w_digit = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        w_lz_blank = (w_idx_nxt != '0);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if ((IDX_W'(i) >= w_idx_nxt) && (w_shadow_nxt[4*i +: 4] != 4'd0)) begin
                w_lz_blank = 1'b0;
            end
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .i_bcd   (w_digit),
        .i_blank (!w_drive || w_lz_blank),
        .o_seg   (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= OFF;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_staging   <= '0;
            r_pending   <= 1'b0;
            r_load_done <= 1'b0;
            r_seg       <= SEG_BLANK;
            r_an        <= '1;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            if (load) begin
                r_staging <= digits_in;
            end
            r_pending   <= load | (r_pending & ~w_commit);
            r_load_done <= w_commit;
            r_seg       <= w_seg_dec;
            r_an        <= w_drive ? ~(NUM_DIGITS'(1) << w_idx_nxt) : '1;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign load_done = r_load_done;
    assign pending   = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, all checked
// against a timeline model of the display (frame position from cycle count).
module tb_seg_scan_ctrl;

    localparam int unsigned ND    = 4;
    localparam int unsigned RD    = 4;
    localparam int unsigned GC    = 1;
    localparam int          SLOT  = RD + GC;
    localparam int          FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic        load_done;
    logic        pending;
    logic [7:0]  seg;
    logic [3:0]  an;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD_CYC   (GC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .digits_in (digits_in),
        .load_done (load_done),
        .pending   (pending),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] ref_seg(input logic [15:0] sh, input int slot);
        logic [3:0] d;
        d = sh[slot*4 +: 4];
`ifdef SEG_SCAN_LZB_EN
        if (slot > 0 && (sh >> (slot*4)) == 16'd0) return 8'hFF;
`endif
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Model: m_phase counts cycles since scanning started (-1 = dark).
    int          m_phase   = -1;
    logic [15:0] m_shadow  = '0;
    logic [15:0] m_staging = '0;
    bit          m_pending = 1'b0;
    bit          m_done    = 1'b0;
    logic [3:0]  m_an      = 4'hF;
    logic [7:0]  m_seg     = 8'hFF;
    bit          m_valid   = 1'b0;

    always @(posedge clk) begin : model
        bit off, boundary, commit;
        int p;
        m_valid = 1'b1;
        if (!rst_n) begin
            m_phase   = -1;
            m_shadow  = '0;
            m_staging = '0;
            m_pending = 1'b0;
            m_done    = 1'b0;
        end else begin
            off      = (m_phase < 0);
            boundary = !off && (m_phase % FRAME == FRAME - 1);
            commit   = m_pending && (off || boundary);
            if (commit) m_shadow = m_staging;
            m_done = commit;
            if (load) begin
                m_staging = digits_in;
                m_pending = 1'b1;
            end else if (commit) begin
                m_pending = 1'b0;
            end
            m_phase = en ? m_phase + 1 : -1;
        end
        if (m_phase < 0) begin
            m_an  = 4'hF;
            m_seg = 8'hFF;
        end else begin
            p = m_phase % FRAME;
            if (p % SLOT < RD) begin
                m_an  = ~(4'b0001 << (p / SLOT));
                m_seg = ref_seg(m_shadow, p / SLOT);
            end else begin
                m_an  = 4'hF;
                m_seg = 8'hFF;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("an", {28'd0, an}, {28'd0, m_an});
            chk("seg", {24'd0, seg}, {24'd0, m_seg});
            chk("load_done", {31'd0, load_done}, {31'd0, m_done});
            chk("pending", {31'd0, pending}, {31'd0, m_pending});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] v, input string tag);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (an == v) return;
            @(negedge clk);
        end
        chk(tag, {28'd0, an}, {28'd0, v});
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            if (load_done) return;
            @(negedge clk);
        end
        chk(tag, {31'd0, load_done}, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        digits_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_seg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        int cnt;
        int gap;

        // Reset with en held high
        rst_n = 1'b0;
        en    = 1'b1;
        cyc(3);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_an", {28'd0, an}, 32'hF);
        rst_n = 1'b1;
        cyc(1);
        chk("first_an", {28'd0, an}, 32'hE);
        chk("first_seg", {24'd0, seg}, 32'hC0);

        // Load while dark, then scan one full frame
        en = 1'b0;
        cyc(2);
        do_load(16'h1234);
        chk("off_pending", {31'd0, pending}, 32'd1);
        cyc(1);
        chk("off_load_done", {31'd0, load_done}, 32'd1);
        en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < RD; k++) begin
                cyc(1);
                chk("scan_an", {28'd0, an}, {28'd0, exp_an[s]});
                chk("scan_seg", {24'd0, seg}, {24'd0, exp_seg[s]});
            end
            cyc(1);
            chk("guard_an", {28'd0, an}, 32'hF);
        end

        // Mid-frame double load: last value wins, one load_done
        cyc(3);
        do_load(16'h0009);
        cyc(1);
        do_load(16'h0008);
        chk("mid_pending", {31'd0, pending}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (load_done) cnt++;
            cyc(1);
        end
        chk("single_done", cnt, 1);
        wait_an(4'hE, "wait_d0_a");
        chk("mid_value", {24'd0, seg}, 32'h80);

        // Zero digits, with or without leading-zero blanking
        do_load(16'h0050);
        wait_done("done_0050");
        wait_an(4'h7, "wait_d3");
`ifdef SEG_SCAN_LZB_EN
        chk("lz_d3", {24'd0, seg}, 32'hFF);
        wait_an(4'hB, "wait_d2");
        chk("lz_d2", {24'd0, seg}, 32'hFF);
`else
        chk("lz_d3", {24'd0, seg}, 32'hC0);
        wait_an(4'hB, "wait_d2");
        chk("lz_d2", {24'd0, seg}, 32'hC0);
`endif
        wait_an(4'hD, "wait_d1");
        chk("lz_d1", {24'd0, seg}, 32'h92);
        wait_an(4'hE, "wait_d0_b");
        chk("lz_d0", {24'd0, seg}, 32'hC0);

        // Non-BCD code blanks its slot; en drop and restart
        do_load(16'h12C5);
        wait_done("done_12C5");
        wait_an(4'hD, "wait_dC");
        chk("code_c", {24'd0, seg}, 32'hFF);
        wait_an(4'hB, "wait_drop");
        en = 1'b0;
        cyc(1);
        chk("drop_an", {28'd0, an}, 32'hF);
        en = 1'b1;
        cyc(1);
        chk("restart_an", {28'd0, an}, 32'hE);

        // Load landing exactly on the frame boundary
        do_load(16'h4321);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_phase >= 0 && m_phase % FRAME == FRAME - 1) break;
            cyc(1);
        end
        do_load(16'h5678);
        chk("bnd_pending", {31'd0, pending}, 32'd1);
        chk("bnd_done", {31'd0, load_done}, 32'd1);
        chk("bnd_seg_old", {24'd0, seg}, 32'hF9);
        gap = 0;
        for (int i = 1; i <= FRAME + 5; i++) begin
            cyc(1);
            gap = i;
            if (load_done) break;
        end
        chk("bnd_gap", gap, FRAME);
        chk("bnd_seg_new", {24'd0, seg}, 32'h80);

        // Reset with a load pending drops it
        do_load(16'h9999);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("rst_drop_pending", {31'd0, pending}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 59) != 0);
            load      = ($urandom_range(0, 14) == 0);
            digits_in = 16'($urandom);
            cyc(1);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
